// File: rtl/mips_harvard_bus_monitor.sv
// Passive Harvard-bus checker/profiler: run status, access counters, watchdog and sticky protocol-error flags.
// Optional BUS_MON_HALT_CHECK_EN widens err_flags to 5 bits and flags a halt whose last fetch was not address 0.
module mips_harvard_bus_monitor #(
   parameter int unsigned TIMEOUT_CYCLES = 10000,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_enable,
   input  logic             active,
   input  logic [31:0]      register_v0,
   input  logic [31:0]      instr_address,
   input  logic             instr_read,
   input  logic [31:0]      data_address,
   input  logic             data_read,
   input  logic             data_write,
   input  logic [3:0]       byteenable,
   output logic [1:0]       state,
   output logic             result_valid,
   output logic [31:0]      final_v0,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] load_count,
   output logic [CNT_W-1:0] store_count,
`ifdef BUS_MON_HALT_CHECK_EN
   output logic [4:0]       err_flags,
`else
   output logic [3:0]       err_flags,
`endif
   output logic [31:0]      first_err_addr
);

`ifdef BUS_MON_HALT_CHECK_EN
   localparam int unsigned ERR_W = 5;
`else
   localparam int unsigned ERR_W = 4;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      DONE    = 2'd2,
      TIMEOUT = 2'd3
   } state_t;

   state_t           state_q;
   logic             start, run_edge, halt, timeout, at_limit, any_data;
   logic [ERR_W-1:0] new_err;
   logic [31:0]      err_addr;
   logic [31:0]      last_fetch;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign state = state_q;

   // The IDLE->RUN edge is itself a counted RUN cycle; the halt and timeout edges count nothing.
   always_comb begin
      at_limit = (cycle_count >= CNT_W'(TIMEOUT_CYCLES));
      start    = (state_q == IDLE) && active;
      halt     = (state_q == RUN) && !active;
      timeout  = (state_q == RUN) && active && at_limit;
      run_edge = start || ((state_q == RUN) && active && !at_limit);
      any_data = data_read || data_write;

      new_err    = '0;
      new_err[0] = run_edge && instr_read && (instr_address[1:0] != 2'b00);
      new_err[1] = run_edge && any_data && (byteenable == 4'hF) && (data_address[1:0] != 2'b00);
      new_err[2] = run_edge && data_read && data_write;
      new_err[3] = run_edge && any_data && (byteenable == 4'h0);
`ifdef BUS_MON_HALT_CHECK_EN
      new_err[4] = halt && (last_fetch != 32'h0);
`endif

      if (new_err[0])
         err_addr = instr_address;
      else if (|new_err[3:1])
         err_addr = data_address;
      else
         err_addr = last_fetch;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         result_valid   <= 1'b0;
         final_v0       <= '0;
         cycle_count    <= '0;
         instr_count    <= '0;
         load_count     <= '0;
         store_count    <= '0;
         err_flags      <= '0;
         first_err_addr <= '0;
         last_fetch     <= '0;
      end else if (clk_enable) begin
         result_valid <= (state_q == DONE) || (state_q == TIMEOUT);

         if (start)
            state_q <= RUN;
         else if (halt) begin
            state_q  <= DONE;
            final_v0 <= register_v0;
         end else if (timeout)
            state_q <= TIMEOUT;

         if (run_edge) begin
            cycle_count <= sat_inc(cycle_count);
            if (instr_read) begin
               instr_count <= sat_inc(instr_count);
               last_fetch  <= instr_address;
            end
            if (data_read)
               load_count <= sat_inc(load_count);
            if (data_write)
               store_count <= sat_inc(store_count);
         end

         err_flags <= err_flags | new_err;
         if ((err_flags == '0) && (new_err != '0))
            first_err_addr <= err_addr;
      end
   end

endmodule

// File: tb/tb_mips_harvard_bus_monitor.sv
// Scoreboard bench for mips_harvard_bus_monitor (TIMEOUT_CYCLES=8); halt checks build only with BUS_MON_HALT_CHECK_EN.
module tb_mips_harvard_bus_monitor;

`ifdef BUS_MON_HALT_CHECK_EN
   localparam int ERR_W = 5;
`else
   localparam int ERR_W = 4;
`endif

   typedef struct packed {
      logic [1:0]       st;
      logic             rv;
      logic [31:0]      v0;
      logic [31:0]      cyc;
      logic [31:0]      ins;
      logic [31:0]      ld;
      logic [31:0]      sc;
      logic [ERR_W-1:0] err;
      logic [31:0]      fa;
   } snap_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             clk_enable, active, instr_read, data_read, data_write;
   logic [31:0]      register_v0, instr_address, data_address;
   logic [3:0]       byteenable;
   logic [1:0]       state;
   logic             result_valid;
   logic [31:0]      final_v0, cycle_count, instr_count, load_count, store_count, first_err_addr;
   logic [ERR_W-1:0] err_flags;

   snap_t exp_q[$];
   snap_t got, exp;
   int    n_pass = 0;
   int    n_total = 0;

   mips_harvard_bus_monitor #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .clk_enable(clk_enable), .active(active),
      .register_v0(register_v0), .instr_address(instr_address), .instr_read(instr_read),
      .data_address(data_address), .data_read(data_read), .data_write(data_write),
      .byteenable(byteenable), .state(state), .result_valid(result_valid),
      .final_v0(final_v0), .cycle_count(cycle_count), .instr_count(instr_count),
      .load_count(load_count), .store_count(store_count), .err_flags(err_flags),
      .first_err_addr(first_err_addr)
   );

   always #5 clk = ~clk;

   function automatic snap_t mk(input logic [1:0] st, input logic rv, input logic [31:0] v0,
                                input int c, input int n, input int l, input int s,
                                input logic [4:0] e, input logic [31:0] fa);
      snap_t r;
      r.st = st; r.rv = rv; r.v0 = v0;
      r.cyc = 32'(c); r.ins = 32'(n); r.ld = 32'(l); r.sc = 32'(s);
      r.err = e[ERR_W-1:0]; r.fa = fa;
      return r;
   endfunction

   function automatic snap_t sample();
      snap_t r;
      r.st = state; r.rv = result_valid; r.v0 = final_v0;
      r.cyc = cycle_count; r.ins = instr_count; r.ld = load_count; r.sc = store_count;
      r.err = err_flags; r.fa = first_err_addr;
      return r;
   endfunction

   task automatic clear_inputs();
      clk_enable = 1'b1; active = 1'b0; instr_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
      register_v0 = '0; instr_address = '0; data_address = '0; byteenable = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      active = 1'b1; instr_read = 1'b1; instr_address = 32'h3;
      #2;
      exp_q.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0, 5'b0, 0));
      got = sample(); exp = exp_q.pop_front(); n_total++;
      if (got !== exp) $display("FAIL reset: actual=%p required=%p", got, exp);
      else n_pass++;
      rst = 1'b1;
   endtask

   task automatic test_basic_run();
      do_reset();
      for (int i = 0; i < 7; i++) begin
         clear_inputs();
         register_v0 = 32'hDEADBEEF;
         if (i < 5) begin
            active = 1'b1; instr_read = 1'b1; instr_address = 32'(16 - 4 * i);
         end
         if (i == 2) begin data_write = 1'b1; data_address = 32'h100; byteenable = 4'hF; end
         if (i == 3) begin data_read = 1'b1; data_address = 32'h202; byteenable = 4'h3; end
         if (i < 5)
            exp_q.push_back(mk(2'd1, 0, 0, i + 1, i + 1, (i >= 3) ? 1 : 0, (i >= 2) ? 1 : 0, 5'b0, 0));
         else
            exp_q.push_back(mk(2'd2, (i == 6), 32'hDEADBEEF, 5, 5, 1, 1, 5'b0, 0));
         step();
         got = sample(); exp = exp_q.pop_front(); n_total++;
         if (got !== exp) $display("FAIL basic_run[%0d]: actual=%p required=%p", i, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < 11; i++) begin
         clear_inputs();
         register_v0 = 32'h12345678;
         active = (i < 10);
         if (i < 8)
            exp_q.push_back(mk(2'd1, 0, 0, i + 1, 0, 0, 0, 5'b0, 0));
         else
            exp_q.push_back(mk(2'd3, (i >= 9), 0, 8, 0, 0, 0, 5'b0, 0));
         step();
         got = sample(); exp = exp_q.pop_front(); n_total++;
         if (got !== exp) $display("FAIL timeout[%0d]: actual=%p required=%p", i, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_done_wins();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         clear_inputs();
         register_v0 = 32'hCAFE0009;
         active = (i < 8);
         if (i < 8)
            exp_q.push_back(mk(2'd1, 0, 0, i + 1, 0, 0, 0, 5'b0, 0));
         else
            exp_q.push_back(mk(2'd2, 0, 32'hCAFE0009, 8, 0, 0, 0, 5'b0, 0));
         step();
         got = sample(); exp = exp_q.pop_front(); n_total++;
         if (got !== exp) $display("FAIL done_wins[%0d]: actual=%p required=%p", i, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_misaligned();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         clear_inputs();
         active = 1'b1;
         case (i)
            0: begin instr_read = 1'b1; instr_address = 32'hBFC00000;
               exp_q.push_back(mk(2'd1, 0, 0, 1, 1, 0, 0, 5'b00000, 32'h0)); end
            1: begin instr_read = 1'b1; instr_address = 32'hBFC00002;
               exp_q.push_back(mk(2'd1, 0, 0, 2, 2, 0, 0, 5'b00001, 32'hBFC00002)); end
            default: begin data_read = 1'b1; data_address = 32'h1001; byteenable = 4'hF;
               exp_q.push_back(mk(2'd1, 0, 0, 3, 2, 1, 0, 5'b00011, 32'hBFC00002)); end
         endcase
         step();
         got = sample(); exp = exp_q.pop_front(); n_total++;
         if (got !== exp) $display("FAIL misaligned[%0d]: actual=%p required=%p", i, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_rw_conflict();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         clear_inputs();
         active = 1'b1;
         if (i == 0) begin
            data_read = 1'b1; data_write = 1'b1; byteenable = 4'h0; data_address = 32'h40;
            exp_q.push_back(mk(2'd1, 0, 0, 1, 0, 1, 1, 5'b01100, 32'h40));
         end else begin
            instr_read = 1'b1; instr_address = 32'h3;
            exp_q.push_back(mk(2'd1, 0, 0, 2, 1, 1, 1, 5'b01101, 32'h40));
         end
         step();
         got = sample(); exp = exp_q.pop_front(); n_total++;
         if (got !== exp) $display("FAIL rw_conflict[%0d]: actual=%p required=%p", i, got, exp);
         else n_pass++;
      end
   endtask

   task automatic test_clk_enable();
      do_reset();
      for (int i = 0; i < 7; i++) begin
         clear_inputs();
         active = 1'b1; instr_read = 1'b1; instr_address = 32'h8;
         if (i < 3)
            exp_q.push_back(mk(2'd1, 0, 0, i + 1, i + 1, 0, 0, 5'b0, 0));
         else if (i < 6) begin
            clk_enable = 1'b0; instr_address = 32'h1; data_read = 1'b1; byteenable = 4'h0;
            exp_q.push_back(mk(2'd1, 0, 0, 3, 3, 0, 0, 5'b0, 0));
         end else
            exp_q.push_back(mk(2'd1, 0, 0, 4, 4, 0, 0, 5'b0, 0));
         step();
         got = sample(); exp = exp_q.pop_front(); n_total++;
         if (got !== exp) $display("FAIL clk_enable[%0d]: actual=%p required=%p", i, got, exp);
         else n_pass++;
      end
      // Assert reset between edges; the check lands well before the next rising edge.
      #2;
      rst = 1'b0;
      #1;
      exp_q.push_back(mk(2'd0, 0, 0, 0, 0, 0, 0, 5'b0, 0));
      got = sample(); exp = exp_q.pop_front(); n_total++;
      if (got !== exp) $display("FAIL async_reset: actual=%p required=%p", got, exp);
      else n_pass++;
      rst = 1'b1;
   endtask

`ifdef BUS_MON_HALT_CHECK_EN
   task automatic test_halt_check();
      for (int k = 0; k < 2; k++) begin
         do_reset();
         for (int i = 0; i < 3; i++) begin
            clear_inputs();
            register_v0 = 32'h55;
            if (i < 2) begin
               active = 1'b1; instr_read = 1'b1;
               instr_address = ((i == 1) == (k == 0)) ? 32'h4 : 32'h0;
               exp_q.push_back(mk(2'd1, 0, 0, i + 1, i + 1, 0, 0, 5'b0, 0));
            end else if (k == 0)
               exp_q.push_back(mk(2'd2, 0, 32'h55, 2, 2, 0, 0, 5'b10000, 32'h4));
            else
               exp_q.push_back(mk(2'd2, 0, 32'h55, 2, 2, 0, 0, 5'b00000, 32'h0));
            step();
            got = sample(); exp = exp_q.pop_front(); n_total++;
            if (got !== exp) $display("FAIL halt_check[%0d][%0d]: actual=%p required=%p", k, i, got, exp);
            else n_pass++;
         end
      end
   endtask
`endif

   initial begin
      clear_inputs();
      test_reset();
      test_basic_run();
      test_timeout();
      test_done_wins();
      test_misaligned();
      test_rw_conflict();
      test_clk_enable();
`ifdef BUS_MON_HALT_CHECK_EN
      test_halt_check();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

endmodule
